// File: rtl/mac_sched_pkg.sv
// Shared types and defaults for the round-robin DSP multiply-add scheduler.
// The tag id field is sized for the largest supported requester count (8).
package mac_sched_pkg;

   localparam int DEFAULT_DATA_W  = 8;
   localparam int DEFAULT_OUT_W   = 17;
   localparam int DEFAULT_DSP_LAT = 3;
   localparam int STATS_W         = 16;
   localparam int MAX_ID_W        = 3;

   typedef struct packed {
      logic                valid;
      logic [MAX_ID_W-1:0] id;
   } tag_t;

   function automatic logic [STATS_W-1:0] satInc(input logic [STATS_W-1:0] value);
      return (&value) ? value : value + 1'b1;
   endfunction

endpackage

// File: rtl/mac_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr_i wins.
// The pointer register itself lives in the scheduler.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               en_i,
   input  logic [ID_W-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] grant_o,
   output logic [ID_W-1:0]    grant_idx_o,
   output logic               any_grant_o
);

   int   cand;
   logic found;

   // Walk the requesters in rotated order and keep only the first hit.
   always_comb begin
      grant_o     = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      cand        = 0;
      if (en_i) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            cand = (int'(ptr_i) + i) % NUM_REQ;
            if (!found && req_i[cand]) begin
               grant_o[cand] = 1'b1;
               grant_idx_o   = ID_W'(cand);
               found         = 1'b1;
            end
         end
      end
      any_grant_o = found;
   end

endmodule

// File: rtl/mac_scheduler.sv
// Shares one fixed-latency DSP multiply-add between NUM_REQ requesters.
// Optional per-requester grant and stall counters when MAC_SCHED_STATS_EN is defined.
module mac_scheduler
   import mac_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = DEFAULT_DATA_W,
   parameter int OUT_W   = DEFAULT_OUT_W,
   parameter int DSP_LAT = DEFAULT_DSP_LAT,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   input  logic [NUM_REQ*DATA_W-1:0] req_c,
   output logic [DATA_W-1:0]         dsp_a,
   output logic [DATA_W-1:0]         dsp_b,
   output logic [DATA_W-1:0]         dsp_c,
   input  logic [OUT_W-1:0]          dsp_p,
   output logic                      rsp_valid,
   output logic [ID_W-1:0]           rsp_id,
   output logic [OUT_W-1:0]          rsp_data,
   output logic                      idle
`ifdef MAC_SCHED_STATS_EN
   ,
   input  logic                      stats_clr,
   output logic [NUM_REQ*STATS_W-1:0] grant_cnt,
   output logic [STATS_W-1:0]        stall_cnt
`endif
);

   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grantIdx;
   logic               anyGrant;

   logic [ID_W-1:0]    ptr_q, ptr_d;
   logic [DATA_W-1:0]  opA_q, opA_d;
   logic [DATA_W-1:0]  opB_q, opB_d;
   logic [DATA_W-1:0]  opC_q, opC_d;
   tag_t               issueTag_q, issueTag_d;
   tag_t               tagPipe_q [DSP_LAT];
   logic               inFlight;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) uArb (
      .req_i       (req_valid),
      .en_i        (en),
      .ptr_i       (ptr_q),
      .grant_o     (grant),
      .grant_idx_o (grantIdx),
      .any_grant_o (anyGrant)
   );

   assign req_ready = grant;

   always_comb begin
      ptr_d      = ptr_q;
      opA_d      = opA_q;
      opB_d      = opB_q;
      opC_d      = opC_q;
      issueTag_d = '0;
      if (anyGrant) begin
         ptr_d          = (grantIdx == ID_W'(NUM_REQ - 1)) ? '0 : grantIdx + 1'b1;
         opA_d          = req_a[int'(grantIdx)*DATA_W +: DATA_W];
         opB_d          = req_b[int'(grantIdx)*DATA_W +: DATA_W];
         opC_d          = req_c[int'(grantIdx)*DATA_W +: DATA_W];
         issueTag_d.valid = 1'b1;
         issueTag_d.id    = MAX_ID_W'(grantIdx);
      end
   end

   // The issue tag rides alongside the operand registers; the DSP_LAT stages
   // behind it track the DSP's own pipeline so the last stage lines up with dsp_p.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q      <= '0;
         opA_q      <= '0;
         opB_q      <= '0;
         opC_q      <= '0;
         issueTag_q <= '0;
         for (int i = 0; i < DSP_LAT; i++) begin
            tagPipe_q[i] <= '0;
         end
      end else begin
         ptr_q        <= ptr_d;
         opA_q        <= opA_d;
         opB_q        <= opB_d;
         opC_q        <= opC_d;
         issueTag_q   <= issueTag_d;
         tagPipe_q[0] <= issueTag_q;
         for (int i = 1; i < DSP_LAT; i++) begin
            tagPipe_q[i] <= tagPipe_q[i-1];
         end
      end
   end

   always_comb begin
      inFlight = issueTag_q.valid;
      for (int i = 0; i < DSP_LAT; i++) begin
         inFlight = inFlight | tagPipe_q[i].valid;
      end
   end

   assign dsp_a     = opA_q;
   assign dsp_b     = opB_q;
   assign dsp_c     = opC_q;
   assign rsp_valid = tagPipe_q[DSP_LAT-1].valid;
   assign rsp_id    = tagPipe_q[DSP_LAT-1].id[ID_W-1:0];
   assign rsp_data  = dsp_p;
   assign idle      = !inFlight && !anyGrant;

`ifdef MAC_SCHED_STATS_EN
   logic [STATS_W-1:0] grantCnt_q [NUM_REQ];
   logic [STATS_W-1:0] stallCnt_q;

   // A grant always coincides with a handshake, since only valid requesters are granted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stallCnt_q <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            grantCnt_q[i] <= '0;
         end
      end else if (stats_clr) begin
         stallCnt_q <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            grantCnt_q[i] <= '0;
         end
      end else begin
         if ((|req_valid) && !en) begin
            stallCnt_q <= satInc(stallCnt_q);
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
               grantCnt_q[i] <= satInc(grantCnt_q[i]);
            end
         end
      end
   end

   always_comb begin
      grant_cnt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         grant_cnt[i*STATS_W +: STATS_W] = grantCnt_q[i];
      end
   end

   assign stall_cnt = stallCnt_q;
`endif

endmodule

// File: tb/tb_mac_scheduler.sv
// Self-checking bench for mac_scheduler: a DSP model drives dsp_p, a queue-based
// reference model checks every cycle, and directed tests pin literal results.
module tb_mac_scheduler;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 8;
   localparam int OUT_W   = 17;
   localparam int L       = 3;
   localparam int ID_W    = 2;

   logic                      clk = 1'b0;
   logic                      rst;
   logic                      en;
   logic [NUM_REQ-1:0]        reqValid;
   logic [NUM_REQ-1:0]        reqReady;
   logic [NUM_REQ*DATA_W-1:0] reqA, reqB, reqC;
   logic [DATA_W-1:0]         dspA, dspB, dspC;
   logic [OUT_W-1:0]          dspP;
   logic                      rspValid;
   logic [ID_W-1:0]           rspId;
   logic [OUT_W-1:0]          rspData;
   logic                      idle;
`ifdef MAC_SCHED_STATS_EN
   logic                      statsClr = 1'b0;
   logic [NUM_REQ*16-1:0]     grantCnt;
   logic [15:0]               stallCnt;
`endif

   logic [DATA_W-1:0] opA [NUM_REQ];
   logic [DATA_W-1:0] opB [NUM_REQ];
   logic [DATA_W-1:0] opC [NUM_REQ];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      int due;
      int id;
      int data;
   } exp_t;

   exp_t expQ [$];
   int   mptr = 0;
   int   rspLog [$];
   int   idLog [$];
   int   grantLog [$];

   mac_scheduler #(
      .NUM_REQ (NUM_REQ),
      .DATA_W  (DATA_W),
      .OUT_W   (OUT_W),
      .DSP_LAT (L),
      .ID_W    (ID_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req_valid (reqValid),
      .req_ready (reqReady),
      .req_a     (reqA),
      .req_b     (reqB),
      .req_c     (reqC),
      .dsp_a     (dspA),
      .dsp_b     (dspB),
      .dsp_c     (dspC),
      .dsp_p     (dspP),
      .rsp_valid (rspValid),
      .rsp_id    (rspId),
      .rsp_data  (rspData),
      .idle      (idle)
`ifdef MAC_SCHED_STATS_EN
      ,
      .stats_clr (statsClr),
      .grant_cnt (grantCnt),
      .stall_cnt (stallCnt)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      reqA = '0;
      reqB = '0;
      reqC = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         reqA[i*DATA_W +: DATA_W] = opA[i];
         reqB[i*DATA_W +: DATA_W] = opB[i];
         reqC[i*DATA_W +: DATA_W] = opC[i];
      end
   end

   // Behavioural DSP: L registers from the operand registers to P, never reset.
   logic [OUT_W-1:0] dspPipe [L];
   always @(posedge clk) begin
      dspPipe[0] <= OUT_W'(dspA) * OUT_W'(dspB) + OUT_W'(dspC);
      for (int i = 1; i < L; i++) dspPipe[i] <= dspPipe[i-1];
   end
   assign dspP = dspPipe[L-1];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [NUM_REQ-1:0] v, input logic e, input int cycles);
      reqValid = v;
      en       = e;
      repeat (cycles) nextCycle();
   endtask

   task automatic setOperands(input int idx, input int a, input int b, input int c);
      opA[idx] = DATA_W'(a);
      opB[idx] = DATA_W'(b);
      opC[idx] = DATA_W'(c);
   endtask

   // Reference model: round-robin from a pointer, queue of results due L+1 cycles after each grant.
   always @(negedge clk) begin
      logic             expHs;
      int               hsIdx;
      int               c;
      int               pending;
      logic             expValid;
      logic [NUM_REQ-1:0] expReady;
      if (rst) begin
         expQ.delete();
         mptr = 0;
      end
      pending  = expQ.size();
      expValid = (pending > 0) && (expQ[0].due == cyc);
      checkOutput("rsp_valid", 32'(rspValid), 32'(expValid));
      if (expValid) begin
         checkOutput("rsp_id", 32'(rspId), 32'(expQ[0].id));
         checkOutput("rsp_data", 32'(rspData), 32'(expQ[0].data));
         void'(expQ.pop_front());
      end
      expHs = 1'b0;
      hsIdx = 0;
      if (en) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            c = (mptr + k) % NUM_REQ;
            if (!expHs && reqValid[c]) begin
               expHs = 1'b1;
               hsIdx = c;
            end
         end
      end
      expReady = expHs ? NUM_REQ'(1) << hsIdx : '0;
      checkOutput("req_ready", 32'(reqReady), 32'(expReady));
      checkOutput("idle", 32'(idle), 32'((pending == 0) && !expHs));
      if (expHs && !rst) begin
         expQ.push_back('{cyc + L + 1, hsIdx, int'(opA[hsIdx]) * int'(opB[hsIdx]) + int'(opC[hsIdx])});
         mptr = (hsIdx + 1) % NUM_REQ;
      end
   end

   always @(negedge clk) begin
      if (rspValid) begin
         rspLog.push_back(int'(rspData));
         idLog.push_back(int'(rspId));
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (reqValid[i] && reqReady[i]) grantLog.push_back(i);
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL timeout actual=running expected=finished");
      $fatal(1, "[TB] simulation timeout");
   end

   initial begin
      int rotData [4];
`ifdef MAC_SCHED_STATS_EN
      int stall0;
`endif
      rotData[0] = 2;
      rotData[1] = 5;
      rotData[2] = 8;
      rotData[3] = 11;
      rst      = 1'b1;
      en       = 1'b0;
      reqValid = '0;
      for (int i = 0; i < NUM_REQ; i++) setOperands(i, 0, 0, 0);
      repeat (2) nextCycle();

      @(negedge clk);
      checkOutput("reset_rsp_valid", 32'(rspValid), 0);
      checkOutput("reset_idle", 32'(idle), 1);
      checkOutput("reset_dsp_a", 32'(dspA), 0);
      checkOutput("reset_req_ready", 32'(reqReady), 0);
      nextCycle();
      rst = 1'b0;

      // Single op from requester 0: 3*4+5 = 17 after DSP_LAT+1 cycles.
      setOperands(0, 3, 4, 5);
      applyStimulus(4'b0001, 1'b1, 0);
      @(negedge clk);
      checkOutput("t1_ready", 32'(reqReady), 1);
      nextCycle();
      reqValid = '0;
      @(negedge clk);
      checkOutput("t1_ready_drop", 32'(reqReady), 0);
      nextCycle();
      nextCycle();
      @(negedge clk);
      checkOutput("t1_early", 32'(rspValid), 0);
      @(negedge clk);
      checkOutput("t1_valid", 32'(rspValid), 1);
      checkOutput("t1_id", 32'(rspId), 0);
      checkOutput("t1_data", 32'(rspData), 17);
      @(negedge clk);
      checkOutput("t1_idle", 32'(idle), 1);
      nextCycle();

      // Max operands on requester 3.
      rspLog.delete();
      idLog.delete();
      setOperands(3, 255, 255, 255);
      applyStimulus(4'b1000, 1'b1, 1);
      applyStimulus(4'b0000, 1'b1, 6);
      checkOutput("max_count", 32'(rspLog.size()), 1);
      if (rspLog.size() == 1) begin
         checkOutput("max_data", 32'(rspLog[0]), 65280);
         checkOutput("max_id", 32'(idLog[0]), 3);
      end

      // All requesters continuously valid: rotation and in-order results.
      for (int i = 0; i < NUM_REQ; i++) setOperands(i, i + 1, 2, i);
      rspLog.delete();
      idLog.delete();
      grantLog.delete();
      applyStimulus(4'b1111, 1'b1, 8);
      applyStimulus(4'b0000, 1'b1, 6);
      checkOutput("rot_grants", 32'(grantLog.size()), 8);
      checkOutput("rot_rsps", 32'(rspLog.size()), 8);
      if (grantLog.size() == 8 && rspLog.size() == 8) begin
         for (int i = 0; i < 8; i++) begin
            checkOutput("rot_grant", 32'(grantLog[i]), 32'(i % 4));
            checkOutput("rot_data", 32'(rspLog[i]), 32'(rotData[i % 4]));
            checkOutput("rot_id", 32'(idLog[i]), 32'(i % 4));
         end
      end

      // Drop en with three operations in flight.
      rspLog.delete();
      grantLog.delete();
      applyStimulus(4'b1111, 1'b1, 3);
      en = 1'b0;
      @(negedge clk);
      checkOutput("endrop_ready", 32'(reqReady), 0);
`ifdef MAC_SCHED_STATS_EN
      stall0 = int'(stallCnt);
`endif
      applyStimulus(4'b1111, 1'b0, 6);
      applyStimulus(4'b0000, 1'b0, 2);
      @(negedge clk);
      checkOutput("endrop_rsps", 32'(rspLog.size()), 3);
      checkOutput("endrop_grants", 32'(grantLog.size()), 3);
      checkOutput("endrop_idle", 32'(idle), 1);
`ifdef MAC_SCHED_STATS_EN
      checkOutput("stall_cnt_delta", 32'(int'(stallCnt) - stall0), 6);
`endif
      nextCycle();

      // Reset with operations in flight, then 0 must beat 2.
      applyStimulus(4'b1111, 1'b1, 2);
      rst      = 1'b1;
      reqValid = '0;
      rspLog.delete();
      idLog.delete();
      nextCycle();
      rst = 1'b0;
      applyStimulus(4'b0101, 1'b1, 0);
      @(negedge clk);
      checkOutput("rst_ready", 32'(reqReady), 1);
      nextCycle();
      applyStimulus(4'b0000, 1'b1, 6);
      checkOutput("rst_rsps", 32'(rspLog.size()), 1);
      if (rspLog.size() == 1) begin
         checkOutput("rst_id", 32'(idLog[0]), 0);
         checkOutput("rst_data", 32'(rspLog[0]), 2);
      end

      // Requesters 1 and 3 only, starting with ptr=2.
      applyStimulus(4'b0010, 1'b1, 1);
      grantLog.delete();
      applyStimulus(4'b1010, 1'b1, 4);
      applyStimulus(4'b0000, 1'b1, 6);
      checkOutput("alt_grants", 32'(grantLog.size()), 4);
      if (grantLog.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            checkOutput("alt_grant", 32'(grantLog[i]), (i % 2 == 0) ? 3 : 1);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
